// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared FSM state type, engine command codes and default
// timing constants for the EEPROM arbiter, engine wrapper and benches.
package eeprom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK,
        ST_WRWAIT,
        ST_FAULT
    } state_e;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;

    // 5 ms write time and a 40 ms watchdog at 50 MHz
    localparam int TWR_CYCLES     = 250000;
    localparam int TIMEOUT_CYCLES = 2000000;

endpackage

// File: rtl/eeprom_rr_arb.sv
// eeprom_rr_arb: 2-way round-robin arbiter with a last-grant pointer.
// Ports: sysclk, rst_n, req_i[1:0], en_i (commit grant), gnt_o one-hot, last_o.
module eeprom_rr_arb
(
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);
    import eeprom_pkg::*;

    logic last_q, last_d;

    // On contention the port that was not granted last wins
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        unique case (1'b1)
            (req_i == 2'b11): gnt_o = last_q ? 2'b01 : 2'b10;
            default:          gnt_o = req_i;
        endcase
        if (en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset value 1 makes port 0 the favoured port
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/eeprom_arb.sv
// eeprom_arb: two-port byte read/write arbiter and sequencer for iic_com.
// Ports: req/we/addr/wdata per port in, ack per port + rdata/busy/fault out;
// engine side start_sig/addr_sig/wrdata out, done_sig/rddata in.
// Optional watchdog with FAULT state: define EEPROM_ARB_TIMEOUT_EN.
module eeprom_arb #(
    parameter int TWR_CYCLES     = eeprom_pkg::TWR_CYCLES,
    parameter int TIMEOUT_CYCLES = eeprom_pkg::TIMEOUT_CYCLES
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       fault,
    output logic [1:0] start_sig,
    output logic [7:0] addr_sig,
    output logic [7:0] wrdata,
    input  logic       done_sig,
    input  logic [7:0] rddata
);
    import eeprom_pkg::*;

    if (TWR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("eeprom_arb: cycle parameters must be >= 1");
    end

    localparam int CW = $clog2(TWR_CYCLES) + 1;
    localparam logic [CW-1:0] TWR_LOAD = CW'(TWR_CYCLES - 1);

    state_e     state_q, state_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] start_q, start_d;
    logic [1:0] ack_q, ack_d;
    logic       busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0] gnt;
    logic       arb_en;
    logic       last_gnt;

`ifdef EEPROM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wdt_q, wdt_d;
    logic          fault_q, fault_d;
`endif

    eeprom_rr_arb u_arb (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .req_i  ({req1, req0}),
        .en_i   (arb_en),
        .gnt_o  (gnt),
        .last_o (last_gnt)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        start_d = start_q;
        ack_d   = 2'b00;
        cnt_d   = cnt_q;
        arb_en  = 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
        wdt_d   = wdt_q;
        fault_d = fault_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    arb_en  = 1'b1;
                    we_d    = gnt[1] ? we1 : we0;
                    addr_d  = gnt[1] ? addr1 : addr0;
                    wdata_d = gnt[1] ? wdata1 : wdata0;
                    start_d = we_d ? CMD_WR : CMD_RD;
                    state_d = ST_BUSY;
`ifdef EEPROM_ARB_TIMEOUT_EN
                    wdt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                // last_gnt holds the port granted for this transfer
                if (done_sig) begin
                    start_d = CMD_IDLE;
                    ack_d   = last_gnt ? 2'b10 : 2'b01;
                    state_d = ST_ACK;
                    if (!we_q) begin
                        rdata_d = rddata;
                    end
                end
`ifdef EEPROM_ARB_TIMEOUT_EN
                else if (wdt_q == TO_LAST) begin
                    start_d = CMD_IDLE;
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    wdt_d = wdt_q + TW'(1);
                end
`endif
            end
            ST_ACK: begin
                if (we_q) begin
                    cnt_d   = TWR_LOAD;
                    state_d = ST_WRWAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRWAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // FAULT is absorbing until reset
            default: begin
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            start_q <= CMD_IDLE;
            ack_q   <= 2'b00;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef EEPROM_ARB_TIMEOUT_EN
            wdt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef EEPROM_ARB_TIMEOUT_EN
            wdt_q   <= wdt_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign start_sig = start_q;
    assign addr_sig  = addr_q;
    assign wrdata    = wdata_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_arb.sv
// tb_eeprom_arb: scoreboard bench for eeprom_arb with a behavioural engine.
// Engine raises done_sig 300 cycles after start_sig; read byte = addr ^ 8'hB5.
module tb_eeprom_arb;
    import eeprom_pkg::*;

    localparam int TWR  = 100;
    localparam int TMO  = 5000;
    localparam int ELAT = 300;
    localparam logic [7:0] RKEY = 8'hB5;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, fault;
    logic [7:0] rdata, addr_sig, wrdata, rddata;
    logic [1:0] start_sig;
    logic       done_sig;

    always #5 sysclk = ~sysclk;

    eeprom_arb #(
        .TWR_CYCLES     (TWR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .fault     (fault),
        .start_sig (start_sig),
        .addr_sig  (addr_sig),
        .wrdata    (wrdata),
        .done_sig  (done_sig),
        .rddata    (rddata)
    );

    typedef struct {
        int         port;
        logic [1:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   ecnt = 0;
    bit   hang = 1'b0;
    bit   inflight = 1'b0;
    bit   prev_done = 1'b0;
    logic [1:0] prev_start = 2'b00;
    bit   stable_bad = 1'b0;
    bit   last_wr = 1'b0;
    int   wr_ack_cyc = 0;
    int   last_gap = -1;
    int   n_starts = 0;
    bit   fault_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    endtask

    always @(posedge sysclk) cyc++;

    // Behavioural iic_com engine
    always @(posedge sysclk) begin
        #2;
        if (done_sig) begin
            done_sig = 1'b0;
        end else if (start_sig != CMD_IDLE && !hang) begin
            ecnt++;
            if (ecnt == ELAT) begin
                done_sig = 1'b1;
                rddata   = addr_sig ^ RKEY;
                ecnt     = 0;
            end
        end else begin
            ecnt = 0;
        end
    end

    // Requesters drop req in the cycle after their ack
    always @(negedge sysclk) begin
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
    end

    // Monitor: pops expected transactions on grant and checks acks
    always @(negedge sysclk) begin
        int ap;
        if (fault) fault_seen = 1'b1;
        if (prev_done) begin
            chk("start_clr_after_done", start_sig, CMD_IDLE);
            chk("ack_after_done", ack0 | ack1, 1);
        end
        if (ack0 || ack1) begin
            ap = ack1 ? (ack0 ? 3 : 1) : 0;
            chk("ack_spurious", prev_done, 1);
            chk("ack_inflight", inflight, 1);
            chk("ack_port", ap, cur.port);
            if (cur.cmd == CMD_RD) chk("rdata", rdata, cur.rdata);
            chk("cmd_stable", stable_bad, 0);
            last_wr    = (cur.cmd == CMD_WR);
            wr_ack_cyc = cyc;
            inflight   = 1'b0;
        end
        if (prev_start == CMD_IDLE && start_sig != CMD_IDLE) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                chk("grant_expected", exp_q.size(), 1);
            end else begin
                cur = exp_q.pop_front();
                chk("start_cmd", start_sig, cur.cmd);
                chk("addr_sig", addr_sig, cur.addr);
                chk("wrdata", wrdata, cur.wdata);
                inflight   = 1'b1;
                stable_bad = 1'b0;
                if (last_wr) begin
                    last_gap = cyc - wr_ack_cyc;
                    chk("twr_gap", last_gap >= TWR + 1, 1);
                    last_wr = 1'b0;
                end
            end
        end else if (start_sig != CMD_IDLE) begin
            if (addr_sig != cur.addr || wrdata != cur.wdata) stable_bad = 1'b1;
        end
        prev_start = start_sig;
        prev_done  = done_sig;
    end

    task automatic set_req(input int p, input bit we, input logic [7:0] a,
                           input logic [7:0] d);
        if (p == 0) begin
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
    endtask

    task automatic push(input int p, input bit we, input logic [7:0] a,
                        input logic [7:0] d);
        exp_t e;
        e.port  = p;
        e.cmd   = we ? CMD_WR : CMD_RD;
        e.addr  = a;
        e.wdata = d;
        e.rdata = a ^ RKEY;
        exp_q.push_back(e);
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int n = 0;
        while ((req0 || req1 || busy || inflight || exp_q.size() != 0)
               && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        chk({"quiet_", tag}, n < budget, 1);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n = 0;
        while (start_sig == CMD_IDLE && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        chk({"start_", tag}, n < budget, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, start_sig, 2'b00);
        chk({tag, "_addr"}, addr_sig, 8'h00);
        chk({tag, "_wrdata"}, wrdata, 8'h00);
        chk({tag, "_acks"}, {ack1, ack0}, 2'b00);
        chk({tag, "_rdata"}, rdata, 8'h00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_fault"}, fault, 1'b0);
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        done_sig = 1'b0; rddata = 8'h00;
        repeat (3) @(negedge sysclk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge sysclk);

        // Port 0 write 0x10 <= 0x5A
        push(0, 1'b1, 8'h10, 8'h5A);
        set_req(0, 1'b1, 8'h10, 8'h5A);
        wait_quiet(1000, "wr0");

        // Port 1 read 0x10 returns 0xA5, rdata holds afterwards
        push(1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b0, 8'h10, 8'h00);
        wait_quiet(1000, "rd1");
        repeat (5) @(negedge sysclk);
        chk("rdata_hold", rdata, 8'hA5);

        // Simultaneous requests alternate 0,1 each round
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 8'h20 + 8'(i), 8'h00);
            push(1, 1'b0, 8'h40 + 8'(i), 8'h00);
            set_req(0, 1'b0, 8'h20 + 8'(i), 8'h00);
            set_req(1, 1'b0, 8'h40 + 8'(i), 8'h00);
            wait_quiet(2000, "rr");
        end

        // req1 arrives during a write; served right after WRWAIT
        push(0, 1'b1, 8'h33, 8'hC3);
        push(1, 1'b0, 8'h55, 8'h00);
        set_req(0, 1'b1, 8'h33, 8'hC3);
        wait_start(50, "wr_pend");
        set_req(1, 1'b0, 8'h55, 8'h00);
        wait_quiet(2000, "pend");
        chk("pending_gap_max", last_gap <= TWR + 3, 1);

        // Asynchronous reset in the middle of BUSY
        push(0, 1'b1, 8'h66, 8'h99);
        set_req(0, 1'b1, 8'h66, 8'h99);
        wait_start(50, "mid_rst");
        repeat (50) @(negedge sysclk);
        #2;
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        chk_reset_vals("async");
        inflight = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        push(0, 1'b0, 8'h01, 8'h00);
        push(1, 1'b0, 8'h02, 8'h00);
        set_req(0, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b0, 8'h02, 8'h00);
        wait_quiet(2000, "post_rst");

        // Engine never completes
        hang = 1'b1;
        push(0, 1'b0, 8'h77, 8'h00);
        set_req(0, 1'b0, 8'h77, 8'h00);
        wait_start(50, "hang");
        t0 = cyc;
`ifdef EEPROM_ARB_TIMEOUT_EN
        begin
            int n = 0;
            while (!fault && n < TMO + 200) begin
                @(negedge sysclk);
                n++;
            end
        end
        chk("timeout_cycles", cyc - t0, TMO);
        chk("fault_set", fault, 1'b1);
        chk("fault_start_clr", start_sig, CMD_IDLE);
        begin
            int s = n_starts;
            req0 = 1'b0;
            set_req(1, 1'b0, 8'h88, 8'h00);
            repeat (300) @(negedge sysclk);
            chk("no_grant_in_fault", n_starts - s, 0);
            chk("fault_sticky", fault, 1'b1);
        end
`else
        repeat (TMO + 200) @(negedge sysclk);
        chk("busy_waits", start_sig, CMD_RD);
        chk("busy_held", busy, 1'b1);
        chk("no_fault_seen", fault_seen, 1'b0);
`endif
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        hang = 1'b0;
        inflight = 1'b0;
        exp_q.delete();
        #1;
        chk("fault_rst", fault, 1'b0);
        chk("start_rst", start_sig, CMD_IDLE);
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
